stage_x_muldiv: RTL and testbench



---
 rtl/stage_x_muldiv_if.sv | 31 +++
 rtl/stage_x_muldiv.sv | 166 ++++++++++++++++
 tb/tb_stage_x_muldiv.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/stage_x_muldiv_if.sv
// stage_x_muldiv_if: bundles the signals between the X stage and the M-extension unit.
//   start        : X stage holds an M op with forwarded operands valid
//   funct3       : M-extension operation select
//   op_a, op_b   : rs1/rs2 after the forwarding muxes
//   flush        : kill the in-flight op (redirect)
//   stall        : freeze PC, FD/X registers and X-stage inputs
//   result       : final M-extension result
//   result_valid : one-cycle pulse, result is valid
// master = X-stage side, slave = mul/div unit.
interface stage_x_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            stall;
  logic [XLEN-1:0] result;
  logic            result_valid;

  modport master (
    output start, funct3, op_a, op_b, flush,
    input  stall, result, result_valid
  );

  modport slave (
    input  start, funct3, op_a, op_b, flush,
    output stall, result, result_valid
  );
endinterface

// File: rtl/stage_x_muldiv.sv
// stage_x_muldiv: iterative RV32M multiply/divide unit for the X stage.
// One shift-add (multiply) or restoring subtract-shift (divide) step per cycle,
// XLEN steps per op. Divide-by-zero and signed overflow finish without iterating.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous, active-high reset
//   bus  : stage_x_muldiv_if.slave (start/funct3/op_a/op_b/flush in,
//          stall/result/result_valid out)
module stage_x_muldiv #(
  parameter int XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  stage_x_muldiv_if.slave       bus
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_f3;
  logic            r_neg;     // product / quotient must be negated
  logic            r_neg_a;   // remainder takes the sign of op_a
  logic [XLEN-1:0] r_hi;      // mul: upper product half; div: partial remainder
  logic [XLEN-1:0] r_lo;      // mul: multiplier shifting out; div: dividend -> quotient
  logic [XLEN-1:0] r_opnd;    // mul: multiplicand magnitude; div: divisor magnitude
  logic [XLEN-1:0] r_final;   // result captured on entry to DONE
  logic [XLEN-1:0] r_result;  // result held between DONE cycles

  logic            w_stall, w_valid;

  // ---------------- operand decode (IDLE) ----------------
  logic            w_is_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic            w_div0, w_ovf, w_special;
  logic [XLEN-1:0] w_special_res;

  assign w_is_div = bus.funct3[2];
  // DIV/REM signed, DIVU/REMU unsigned; MUL/MULH both signed, MULHSU a only, MULHU none
  assign w_a_sgn  = w_is_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
  assign w_b_sgn  = w_is_div ? ~bus.funct3[0] : ~bus.funct3[1];
  assign w_a_neg  = w_a_sgn & bus.op_a[XLEN-1];
  assign w_b_neg  = w_b_sgn & bus.op_b[XLEN-1];
  assign w_a_mag  = w_a_neg ? -bus.op_a : bus.op_a;
  assign w_b_mag  = w_b_neg ? -bus.op_b : bus.op_b;

  assign w_div0    = w_is_div & (bus.op_b == '0);
  assign w_ovf     = w_is_div & ~bus.funct3[0] & (bus.op_a == {1'b1, {(XLEN-1){1'b0}}})
                   & (bus.op_b == '1);
  assign w_special = w_div0 | w_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div0) w_special_res = bus.funct3[1] ? bus.op_a : '1;
    else        w_special_res = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // ---------------- iteration step (CALC) ----------------
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_shift;
  logic            w_borrow;
  logic [XLEN-1:0] w_diff;
  logic [XLEN-1:0] w_hi_nx, w_lo_nx;

  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  // shifted remainder needs XLEN+1 bits; when no borrow the difference fits in XLEN
  assign w_shift   = {r_hi, r_lo[XLEN-1]};
  assign w_borrow  = (w_shift < {1'b0, r_opnd});
  assign w_diff    = w_shift[XLEN-1:0] - r_opnd;

  always_comb begin
    w_hi_nx = w_mul_sum[XLEN:1];
    w_lo_nx = {w_mul_sum[0], r_lo[XLEN-1:1]};
    if (r_f3[2]) begin
      w_hi_nx = w_borrow ? w_shift[XLEN-1:0] : w_diff;
      w_lo_nx = {r_lo[XLEN-2:0], ~w_borrow};
    end
  end

  // ---------------- sign fix-up on the final step ----------------
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_calc_res;

  assign w_prod_s = r_neg ? -{w_hi_nx, w_lo_nx} : {w_hi_nx, w_lo_nx};

  always_comb begin
    w_calc_res = '0;
    if (!r_f3[2])     w_calc_res = (r_f3[1:0] == 2'b00) ? w_prod_s[XLEN-1:0]
                                                        : w_prod_s[2*XLEN-1:XLEN];
    else if (r_f3[1]) w_calc_res = r_neg_a ? -w_hi_nx : w_hi_nx;
    else              w_calc_res = r_neg ? -w_lo_nx : w_lo_nx;
  end

  // ---------------- FSM ----------------
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_valid = 1'b0;
    if (bus.flush) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (bus.start) begin
          w_stall = 1'b1;
          w_next  = w_special ? S_DONE : S_CALC;
        end
        S_CALC: begin
          w_stall = 1'b1;
          if (r_cnt == CW'(XLEN-1)) w_next = S_DONE;
        end
        S_DONE: begin
          w_valid = 1'b1;
          w_next  = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_f3     <= '0;
      r_neg    <= 1'b0;
      r_neg_a  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_final  <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (!bus.flush) begin
        unique case (r_state)
          S_IDLE: if (bus.start) begin
            r_f3    <= bus.funct3;
            r_neg   <= w_a_neg ^ w_b_neg;
            r_neg_a <= w_a_neg;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= w_is_div ? w_a_mag : w_b_mag;
            r_opnd  <= w_is_div ? w_b_mag : w_a_mag;
            if (w_special) r_final <= w_special_res;
          end
          S_CALC: begin
            r_hi  <= w_hi_nx;
            r_lo  <= w_lo_nx;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(XLEN-1)) r_final <= w_calc_res;
          end
          S_DONE: r_result <= r_final;
          default: ;
        endcase
      end
    end
  end

  assign bus.stall        = w_stall;
  assign bus.result_valid = w_valid;
  // New value shows during the DONE pulse, then the held copy takes over.
  assign bus.result       = (r_state == S_DONE) ? r_final : r_result;

endmodule

// File: tb/tb_stage_x_muldiv.sv
module tb_stage_x_muldiv;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stage_x_muldiv_if #(.XLEN(32)) bus();
  stage_x_muldiv #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every result_valid pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (bus.result_valid !== 1'b0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected result_valid: got %b expected 0 (cycle %0d)", bus.result_valid, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, " result"}, bus.result, mon_e.res);
        chk({mon_e.name, " valid cycle"}, 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // issue one op; stall expected in cycles 0..lat-1, DONE in cycle lat
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    exp_t e;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = f3; bus.op_a = a; bus.op_b = b;
    e.res = exp; e.cyc = cyc + lat; e.name = name;
    sb.push_back(e);
    for (int i = 0; i <= lat; i++) begin
      @(negedge clk);
      chk({name, " stall"}, 32'(bus.stall), 32'(i < lat));
      if (i == 3) begin  // operands latched at start; later changes must not matter
        bus.op_a = $urandom;
        bus.op_b = $urandom;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
  endtask

  // start an op, then kill it with flush or rst in cycle 'at'
  task automatic abort_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input int at, input bit use_rst,
                          input logic [31:0] held);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = f3; bus.op_a = a; bus.op_b = b;
    for (int i = 0; i < at; i++) begin
      @(negedge clk);
      chk({name, " stall pre-abort"}, 32'(bus.stall), 32'd1);
    end
    @(posedge clk); #1;
    if (use_rst) rst = 1'b1; else bus.flush = 1'b1;
    @(negedge clk);
    if (!use_rst) chk({name, " stall in flush cycle"}, 32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus.flush = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    chk({name, " stall after abort"}, 32'(bus.stall), 32'd0);
    chk({name, " result after abort"}, bus.result, held);
    idle(40);  // monitor flags any stray result_valid
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.funct3 = 3'd0; bus.op_a = '0; bus.op_b = '0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset stall", 32'(bus.stall), 32'd0);
    chk("reset result_valid", 32'(bus.result_valid), 32'd0);
    chk("reset result", bus.result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("MUL 7*-3",        3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33); idle(1);
    run_op("MULH min*min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33); idle(1);
    run_op("MULHU max*max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33); idle(1);
    run_op("MULHSU -1*max",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33); idle(1);

    run_op("DIV 5/0",         3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);  idle(1);
    run_op("REM 5%0",         3'b110, 32'd5,        32'd0,        32'd5,        1);  idle(1);
    run_op("DIV ovf",         3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);  idle(1);
    run_op("REM ovf",         3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);  idle(1);
    run_op("DIVU 9/0",        3'b101, 32'd9,        32'd0,        32'hFFFFFFFF, 1);  idle(1);

    run_op("DIV -7/2",        3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33); idle(1);
    run_op("REM -7%2",        3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33); idle(1);
    run_op("DIV 20/-3",       3'b100, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 33); idle(1);
    run_op("REM 20%-3",       3'b110, 32'd20,       32'hFFFFFFFD, 32'd2,        33); idle(1);
    run_op("DIVU 100/7",      3'b101, 32'd100,      32'd7,        32'h0000000E, 33); idle(1);
    run_op("REMU 100%7",      3'b111, 32'd100,      32'd7,        32'd2,        33); idle(1);

    abort_op("flush MUL", 3'b000, 32'd7, 32'd3, 10, 1'b0, 32'd2);
    run_op("MULHU 3*5",       3'b011, 32'd3,        32'd5,        32'd0,        33); idle(1);

    // back-to-back: second op starts the cycle right after DONE
    run_op("b2b DIVU 100/7",  3'b101, 32'd100,      32'd7,        32'h0000000E, 33);
    run_op("b2b MUL 6*7",     3'b000, 32'd6,        32'd7,        32'h0000002A, 33); idle(1);

    abort_op("rst MUL", 3'b000, 32'd11, 32'd13, 5, 1'b1, 32'd0);
    run_op("MUL after rst",   3'b000, 32'd11,       32'd13,       32'd143,      33); idle(5);

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
